// File: rtl/cl_serial_in.sv
// rtl/cl_serial_in.sv - Camera Link SerTC receiver with automatic baud measurement
//
// Purpose: receives 8N1 bytes on the Camera Link SerTC pair. The bit period is
// learned from the shortest qualified low pulse seen on the line. Received bytes
// are pushed into a downstream FIFO.
//
// Ports:
//   clk_fix        fixed system clock, all logic on rising edge
//   rst_fix_n      synchronous active-low reset
//   cl_sertc_p/n   SerTC differential pair
//   lvds_swap      set to undo a P/N swap on the board
//   baud_clear     one-cycle pulse, restarts baud measurement
//   fifo_full      downstream RX FIFO full
//   fifo_wen       one-cycle write strobe
//   fifo_din       received byte, held until the next write
//   measured_baud  bit period in clocks minus 1 (0 = unknown)
//   baud_valid     measured_baud is non-zero
//   frame_err      one-cycle pulse: stop bit sampled low
//   overrun_err    one-cycle pulse: good byte dropped, FIFO full

module cl_serial_in #(
    parameter int GLITCH_MIN = 16
) (
    input  logic        clk_fix,
    input  logic        rst_fix_n,
    input  logic        cl_sertc_p,
    input  logic        cl_sertc_n,
    input  logic        lvds_swap,
    input  logic        baud_clear,
    input  logic        fifo_full,
    output logic        fifo_wen,
    output logic [7:0]  fifo_din,
    output logic [15:0] measured_baud,
    output logic        baud_valid,
    output logic        frame_err,
    output logic        overrun_err
);

    localparam logic [2:0] s_IDLE  = 3'd0;
    localparam logic [2:0] s_START = 3'd1;
    localparam logic [2:0] s_DATA  = 3'd2;
    localparam logic [2:0] s_STOP  = 3'd3;
    localparam logic [2:0] s_BREAK = 3'd4;

    // Behavioural stand-in for the LVDS_33 differential input buffer.
    logic line_buf;
    logic line_raw;
    assign line_buf = cl_sertc_p & ~cl_sertc_n;
    assign line_raw = line_buf ^ lvds_swap;

    // Two-flop synchronizer; resets to the idle (mark) level.
    logic [1:0] sync_q;
    logic       rx_s;
    logic       rx_d;
    logic       rx_fall;
    logic       rx_rise;

    always_ff @(posedge clk_fix) begin
        if (!rst_fix_n) begin
            sync_q <= 2'b11;
            rx_d   <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_raw};
            rx_d   <= sync_q[1];
        end
    end

    assign rx_s    = sync_q[1];
    assign rx_fall = rx_d & ~rx_s;
    assign rx_rise = ~rx_d & rx_s;

    // Low-run measurement. The first low clock loads 1 so that on the rising
    // edge low_cnt equals the number of clocks the line was low.
    logic [15:0] low_cnt;
    logic [15:0] min_width;

    always_ff @(posedge clk_fix) begin
        if (!rst_fix_n) begin
            low_cnt <= 16'd0;
        end else if (rx_fall) begin
            low_cnt <= 16'd1;
        end else if (!rx_s && low_cnt != 16'hFFFF) begin
            low_cnt <= low_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_fix) begin
        if (!rst_fix_n || baud_clear) begin
            min_width     <= 16'hFFFF;
            measured_baud <= 16'd0;
        end else if (rx_rise && low_cnt >= 16'(GLITCH_MIN) && low_cnt < min_width) begin
            min_width     <= low_cnt;
            measured_baud <= low_cnt - 16'd1;
        end
    end

    assign baud_valid = (measured_baud != 16'd0);

    // Receive FSM
    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] bit_period;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        wen_c;
    logic        ovr_c;
    logic        frm_c;

    always_ff @(posedge clk_fix) begin
        if (!rst_fix_n) begin
            state <= s_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            s_IDLE:  if (rx_fall && measured_baud != 16'd0) state_nxt = s_START;
            s_START: if (cnt == 16'd0) state_nxt = rx_s ? s_IDLE : s_DATA;
            s_DATA:  if (cnt == 16'd0 && bit_idx == 3'd7) state_nxt = s_STOP;
            s_STOP:  if (cnt == 16'd0) state_nxt = rx_s ? s_IDLE : s_BREAK;
            s_BREAK: if (rx_s) state_nxt = s_IDLE;
            default: state_nxt = s_IDLE;
        endcase
    end

    always_comb begin
        wen_c = 1'b0;
        ovr_c = 1'b0;
        frm_c = 1'b0;
        if (state == s_STOP && cnt == 16'd0) begin
            wen_c = rx_s & ~fifo_full;
            ovr_c = rx_s & fifo_full;
            frm_c = ~rx_s;
        end
    end

    // Bit timing datapath. bit_period is latched at the start edge so a
    // measurement update mid-byte cannot disturb the byte in flight.
    always_ff @(posedge clk_fix) begin
        if (!rst_fix_n) begin
            bit_period <= 16'd0;
            cnt        <= 16'd0;
            bit_idx    <= 3'd0;
            shift      <= 8'd0;
        end else begin
            case (state)
                s_IDLE: begin
                    if (rx_fall && measured_baud != 16'd0) begin
                        bit_period <= measured_baud;
                        cnt        <= measured_baud >> 1;
                    end
                end
                s_START: begin
                    if (cnt == 16'd0) begin
                        cnt     <= bit_period;
                        bit_idx <= 3'd0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                s_DATA: begin
                    if (cnt == 16'd0) begin
                        shift[bit_idx] <= rx_s;
                        cnt            <= bit_period;
                        if (bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                s_STOP: begin
                    if (cnt != 16'd0) cnt <= cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_fix) begin
        if (!rst_fix_n) begin
            fifo_wen    <= 1'b0;
            fifo_din    <= 8'd0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            fifo_wen    <= wen_c;
            frame_err   <= frm_c;
            overrun_err <= ovr_c;
            if (wen_c) fifo_din <= shift;
        end
    end

endmodule
